fifo_rd_ctrl_sync: RTL and testbench

//  Parametrised read-side controller for the dual-clock FIFO; lives entirely in the read clock domain.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_rd_ctrl_sync_if.sv | 30 +++
 rtl/fifo_sync_chain.sv | 29 ++
 rtl/fifo_rd_ctrl_sync.sv | 102 ++++++++++
 tb/tb_fifo_rd_ctrl_sync.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width/depth rules and gray/binary conversion.
// Reused by both the read-side and write-side controllers.
package fifo_pkg;

   function automatic int ptr_width(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   // Zero-extended operands convert correctly, so callers size-cast in and out.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync_if.sv
// Read-side FIFO controller bus: write pointer in, read request/clear in,
// read address, gray read pointer and status flags out.
interface fifo_rd_ctrl_sync_if
   import fifo_pkg::*;
#(
   parameter int ADDR_W = 4
);
   localparam int PTR_W = ptr_width(ADDR_W);

   logic [PTR_W-1:0]  wptr;
   logic              rinc;
   logic              rclr_err;
   logic [ADDR_W-1:0] raddr;
   logic [PTR_W-1:0]  rptr;
   logic              rempty;
   logic              ralmost_empty;
   logic [PTR_W-1:0]  rlevel;
   logic              runderflow;

   modport master (
      output wptr, rinc, rclr_err,
      input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
   );

   modport slave (
      input  wptr, rinc, rclr_err,
      output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
   );

endinterface

// File: rtl/fifo_sync_chain.sv
// Reset-clearable multi-flop synchroniser for a gray-coded pointer crossing clocks.
module fifo_sync_chain #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain_q;
   logic [STAGES-1:0][WIDTH-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl_sync.sv
// Read-domain controller of the dual-clock FIFO: pointers, empty, level, almost-empty.
// Define FIFO_RD_UNDERFLOW_EN to build the sticky underflow flag; otherwise it reads 0.
module fifo_rd_ctrl_sync
   import fifo_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 2
) (
   input logic                rclk,
   input logic                rrst_n,
   fifo_rd_ctrl_sync_if.slave bus
);

   localparam int          PTR_W  = ptr_width(ADDR_W);
   localparam logic [31:0] AE_LIM = AE_THRESH;

   logic [PTR_W-1:0]  wq_s;
   logic [PTR_W-1:0]  wbin_s;
   logic              ren;
   logic [PTR_W-1:0]  rbin_q, rbin_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic              rempty_q, rempty_d;
   logic              ralmost_empty_q, ralmost_empty_d;
   logic [PTR_W-1:0]  rlevel_q, rlevel_d;

   fifo_sync_chain #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d     (bus.wptr),
      .q     (wq_s)
   );

   // Flags are computed from the next read pointer so the last read flags empty on its own edge.
   always_comb begin
      ren             = bus.rinc & ~rempty_q;
      rbin_d          = rbin_q + PTR_W'(ren);
      raddr_d         = rbin_d[ADDR_W-1:0];
      rptr_d          = PTR_W'(bin2gray(32'(rbin_d)));
      wbin_s          = PTR_W'(gray2bin(32'(wq_s)));
      rlevel_d        = wbin_s - rbin_d;
      rempty_d        = (rptr_d == wq_s);
      ralmost_empty_d = (32'(rlevel_d) <= AE_LIM);
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rbin_q          <= '0;
         raddr_q         <= '0;
         rptr_q          <= '0;
         rempty_q        <= 1'b1;
         ralmost_empty_q <= 1'b1;
         rlevel_q        <= '0;
      end else begin
         rbin_q          <= rbin_d;
         raddr_q         <= raddr_d;
         rptr_q          <= rptr_d;
         rempty_q        <= rempty_d;
         ralmost_empty_q <= ralmost_empty_d;
         rlevel_q        <= rlevel_d;
      end
   end

   assign bus.raddr         = raddr_q;
   assign bus.rptr          = rptr_q;
   assign bus.rempty        = rempty_q;
   assign bus.ralmost_empty = ralmost_empty_q;
   assign bus.rlevel        = rlevel_q;

`ifdef FIFO_RD_UNDERFLOW_EN
   logic runderflow_q, runderflow_d;

   // A new underflow beats a clear on the same edge.
   always_comb begin
      runderflow_d = runderflow_q;
      if (bus.rinc && rempty_q) begin
         runderflow_d = 1'b1;
      end else if (bus.rclr_err) begin
         runderflow_d = 1'b0;
      end
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         runderflow_q <= 1'b0;
      end else begin
         runderflow_q <= runderflow_d;
      end
   end

   assign bus.runderflow = runderflow_q;
`else
   logic unused_rclr_err;
   assign unused_rclr_err = bus.rclr_err;
   assign bus.runderflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl_sync.sv
// Directed bench for fifo_rd_ctrl_sync (ADDR_W=3, SYNC_STAGES=2, AE_THRESH=2);
// runderflow expectations follow FIFO_RD_UNDERFLOW_EN.
module tb_fifo_rd_ctrl_sync;

`ifdef FIFO_RD_UNDERFLOW_EN
   localparam logic UND = 1'b1;
`else
   localparam logic UND = 1'b0;
`endif

   logic rclk = 1'b0;
   logic rrst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [3:0] wbin;
   logic [3:0] rbin_m;
   logic [3:0] rb;
   logic [3:0] prev_rptr;

   logic [3:0] drain_rptr  [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
   logic [3:0] drain_level [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
   logic       drain_ae    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       drain_empty [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   fifo_rd_ctrl_sync_if #(.ADDR_W(3)) bus ();

   fifo_rd_ctrl_sync #(
      .ADDR_W      (3),
      .SYNC_STAGES (2),
      .AE_THRESH   (2)
   ) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (bus)
   );

   always #5 rclk = ~rclk;

   function automatic logic [3:0] gray4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic rst_n_i, input logic rinc_i, input logic clr_i);
      rrst_n       = rst_n_i;
      bus.rinc     = rinc_i;
      bus.rclr_err = clr_i;
      bus.wptr     = gray4(wbin);
      @(posedge rclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [2:0] raddr, input logic [3:0] rptr,
                           input logic empty, input logic ae, input logic [3:0] level, input logic und);
      checkOutput({tag, "/raddr"}, 32'(bus.raddr), 32'(raddr));
      checkOutput({tag, "/rptr"}, 32'(bus.rptr), 32'(rptr));
      checkOutput({tag, "/rempty"}, 32'(bus.rempty), 32'(empty));
      checkOutput({tag, "/ralmost_empty"}, 32'(bus.ralmost_empty), 32'(ae));
      checkOutput({tag, "/rlevel"}, 32'(bus.rlevel), 32'(level));
      checkOutput({tag, "/runderflow"}, 32'(bus.runderflow), 32'(und));
   endtask

   initial begin
      wbin = 4'd5;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkAll("reset", 3'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);

      // Write pointer only becomes visible on the third edge after release.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("fill_e1/rempty", 32'(bus.rempty), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("fill_e2/rempty", 32'(bus.rempty), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkAll("fill", 3'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0);

      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkAll($sformatf("drain%0d", k + 1), 3'(k + 1), drain_rptr[k], drain_empty[k],
                  drain_ae[k], drain_level[k], 1'b0);
      end

      applyStimulus(1'b1, 1'b1, 1'b0);
      checkAll("underflow", 3'd5, 4'b0111, 1'b1, 1'b1, 4'd0, UND);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("set_wins/runderflow", 32'(bus.runderflow), 32'(UND));
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("clear/runderflow", 32'(bus.runderflow), 32'd0);

      // Four write bursts of 5, each drained: crosses raddr 7->0 and rbin 15->0.
      rbin_m    = 4'd5;
      prev_rptr = gray4(rbin_m);
      for (int r = 0; r < 4; r++) begin
         wbin = wbin + 4'd5;
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("wrap%0d_e1/rempty", r), 32'(bus.rempty), 32'd1);
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("wrap%0d_e2/rempty", r), 32'(bus.rempty), 32'd1);
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkAll($sformatf("wrap%0d_view", r), rbin_m[2:0], gray4(rbin_m), 1'b0, 1'b0, 4'd5, 1'b0);
         for (int k = 1; k <= 5; k++) begin
            rb = rbin_m + 4'(k);
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkAll($sformatf("wrap%0d_rd%0d", r, k), rb[2:0], gray4(rb), (k == 5),
                     ((5 - k) <= 2), 4'(5 - k), 1'b0);
            checkOutput($sformatf("wrap%0d_rd%0d/gray_step", r, k),
                        32'($countones(bus.rptr ^ prev_rptr)), 32'd1);
            prev_rptr = gray4(rb);
         end
         rbin_m = rbin_m + 4'd5;
      end

      // rbin=9, wbin=9 here; bring level to 1 then race the last read against a new write.
      wbin = 4'd10;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkAll("race_setup", 3'd1, 4'b1101, 1'b0, 1'b1, 4'd1, 1'b0);
      wbin = 4'd11;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkAll("race", 3'd2, 4'b1111, 1'b1, 1'b1, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("race_e2/rempty", 32'(bus.rempty), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkAll("race_e3", 3'd2, 4'b1111, 1'b0, 1'b1, 4'd1, 1'b0);

      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("mid_last/rempty", 32'(bus.rempty), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("mid_under/runderflow", 32'(bus.runderflow), 32'(UND));
      wbin = 4'd14;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkAll("mid_setup", 3'd3, 4'b1110, 1'b0, 1'b0, 4'd3, UND);

      wbin = 4'd0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkAll("mid_reset", 3'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("post_reset/rempty", 32'(bus.rempty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
